// File: rtl/ss_seq_pkg.sv
// Save-state sequencer shared types and defaults.
// Imported by the interface, the timer and the sequencer top.
package ss_seq_pkg;

  localparam int SS_LEN_DEF = 128;
  localparam int WE_LEN_DEF = 4;
  localparam int SS_AW      = 8;

  typedef enum logic [2:0] {
    IDLE,
    S_SETUP,
    S_CAP,
    S_BUF,
    L_BUF,
    L_WE,
    DONE
  } state_e;

endpackage

// File: rtl/ss_seq_if.sv
// Mapper save-state port and buffer port of the sequencer.
// The master side is the sequencer; the slave side is mapper plus buffer.
interface ss_seq_if;
  import ss_seq_pkg::*;

  logic             ss_act;
  logic [SS_AW-1:0] ss_addr;
  logic             ss_we;
  logic [7:0]       ss_wdat;
  logic [7:0]       ss_rdat;
  logic             buf_req;
  logic             buf_we;
  logic [SS_AW-1:0] buf_addr;
  logic [7:0]       buf_wdat;
  logic             buf_ack;
  logic [7:0]       buf_rdat;

  modport master (
    output ss_act, ss_addr, ss_we, ss_wdat,
    output buf_req, buf_we, buf_addr, buf_wdat,
    input  ss_rdat, buf_ack, buf_rdat
  );

  modport slave (
    input  ss_act, ss_addr, ss_we, ss_wdat,
    input  buf_req, buf_we, buf_addr, buf_wdat,
    output ss_rdat, buf_ack, buf_rdat
  );

endinterface

// File: rtl/ss_we_timer.sv
// Loadable down-counter timing the mapper write-strobe window.
// tc_o marks the last cycle of the window while enabled.
module ss_we_timer #(
  parameter int WE_LEN = 4
) (
  input  logic clk,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(WE_LEN + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(WE_LEN - 1);
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign tc_o = en_i && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ss_seq.sv
// Save-state sequencer: copies SS_LEN bytes between the mapper
// save-state port and a handshaked byte buffer, in either direction.
module ss_seq
  import ss_seq_pkg::*;
#(
  parameter int SS_LEN = SS_LEN_DEF,
  parameter int WE_LEN = WE_LEN_DEF
) (
  input  logic clk,
  input  logic map_rst,
  input  logic save_req,
  input  logic load_req,
  output logic busy,
  output logic done,
  ss_seq_if.master bus
);

  // One spare bit so a 256-byte transfer can count past 255.
  localparam logic [SS_AW:0] LAST = (SS_AW + 1)'(SS_LEN - 1);

  state_e         state_q, state_d;
  logic [SS_AW:0] addr_q, addr_d;
  logic [7:0]     wdat_q, wdat_d;
  logic [7:0]     bwdat_q, bwdat_d;
  logic           tmr_load;
  logic           tmr_tc;
  logic           last;

  assign last = (addr_q == LAST);

  ss_we_timer #(
    .WE_LEN(WE_LEN)
  ) u_tmr (
    .clk   (clk),
    .rst_i (map_rst),
    .load_i(tmr_load),
    .en_i  (state_q == L_WE),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    bwdat_d  = bwdat_q;
    tmr_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (save_req) begin
          state_d = S_SETUP;
        end else if (load_req) begin
          state_d = L_BUF;
        end
      end
      S_SETUP: state_d = S_CAP;
      S_CAP: begin
        bwdat_d = bus.ss_rdat;
        state_d = S_BUF;
      end
      S_BUF: begin
        if (bus.buf_ack) begin
          addr_d  = addr_q + 1'b1;
          state_d = last ? DONE : S_SETUP;
        end
      end
      L_BUF: begin
        if (bus.buf_ack) begin
          wdat_d   = bus.buf_rdat;
          tmr_load = 1'b1;
          state_d  = L_WE;
        end
      end
      L_WE: begin
        if (tmr_tc) begin
          addr_d  = addr_q + 1'b1;
          state_d = last ? DONE : L_BUF;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (map_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      bwdat_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      bwdat_q <= bwdat_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign bus.ss_act   = busy;
  assign bus.ss_addr  = addr_q[SS_AW-1:0];
  assign bus.ss_we    = (state_q == L_WE);
  assign bus.ss_wdat  = wdat_q;
  assign bus.buf_req  = (state_q == S_BUF) || (state_q == L_BUF);
  assign bus.buf_we   = (state_q == S_BUF);
  assign bus.buf_addr = addr_q[SS_AW-1:0];
  assign bus.buf_wdat = bwdat_q;

endmodule

// File: tb/tb_ss_seq.sv
// Bench for ss_seq: three instances (SS_LEN 4, 128, 256) driven one at a
// time against a timeline model of save/load transfers.
module tb_ss_seq;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       act;
    logic       we;
    logic       req;
    logic       bwe;
    logic [7:0] addr;
    logic [7:0] baddr;
    logic [7:0] wdat;
    logic [7:0] bwdat;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       map_rst, save_req, load_req, ack;
  logic [7:0] brdat;
  int         sel;
  int         n_run, n_fail;

  logic [7:0] map_mem [256];
  logic [7:0] buf_mem [256];
  logic [7:0] map_wr  [256];

  int wr_cnt, stb_cnt, rst_cnt, done_cnt, max_addr;
  logic we_prev;

  logic       e_busy, e_done, e_we, e_req, e_bwe;
  logic [7:0] e_addr, e_wdat, e_bwdat;
  int         hold_b, hold_d;

  ss_seq_if if0 ();
  ss_seq_if if1 ();
  ss_seq_if if2 ();

  logic busy0, busy1, busy2, done0, done1, done2;
  obs_t ob0, ob1, ob2, o;

  ss_seq #(.SS_LEN(4), .WE_LEN(2)) u0 (
    .clk(clk), .map_rst(map_rst),
    .save_req(save_req && sel == 0), .load_req(load_req && sel == 0),
    .busy(busy0), .done(done0), .bus(if0)
  );
  ss_seq #(.SS_LEN(128), .WE_LEN(4)) u1 (
    .clk(clk), .map_rst(map_rst),
    .save_req(save_req && sel == 1), .load_req(load_req && sel == 1),
    .busy(busy1), .done(done1), .bus(if1)
  );
  ss_seq #(.SS_LEN(256), .WE_LEN(3)) u2 (
    .clk(clk), .map_rst(map_rst),
    .save_req(save_req && sel == 2), .load_req(load_req && sel == 2),
    .busy(busy2), .done(done2), .bus(if2)
  );

  assign if0.ss_rdat  = map_mem[if0.ss_addr];
  assign if1.ss_rdat  = map_mem[if1.ss_addr];
  assign if2.ss_rdat  = map_mem[if2.ss_addr];
  assign if0.buf_ack  = ack && sel == 0;
  assign if1.buf_ack  = ack && sel == 1;
  assign if2.buf_ack  = ack && sel == 2;
  assign if0.buf_rdat = brdat;
  assign if1.buf_rdat = brdat;
  assign if2.buf_rdat = brdat;

  assign ob0 = {busy0, done0, if0.ss_act, if0.ss_we, if0.buf_req,
                if0.buf_we, if0.ss_addr, if0.buf_addr, if0.ss_wdat,
                if0.buf_wdat};
  assign ob1 = {busy1, done1, if1.ss_act, if1.ss_we, if1.buf_req,
                if1.buf_we, if1.ss_addr, if1.buf_addr, if1.ss_wdat,
                if1.buf_wdat};
  assign ob2 = {busy2, done2, if2.ss_act, if2.ss_we, if2.buf_req,
                if2.buf_we, if2.ss_addr, if2.buf_addr, if2.ss_wdat,
                if2.buf_wdat};
  assign o = (sel == 0) ? ob0 : (sel == 1) ? ob1 : ob2;

  // Toy mapper and buffer observers for the selected instance.
  always @(posedge clk) begin
    if (o.req === 1'b1 && o.bwe === 1'b1 && ack) begin
      buf_mem[o.baddr] = o.bwdat;
      wr_cnt++;
    end
    if (o.we === 1'b1 && we_prev !== 1'b1) begin
      stb_cnt++;
      if (o.addr == 8'd0) rst_cnt++;
    end
    if (o.we === 1'b1) map_wr[o.addr] = o.wdat;
    we_prev = o.we;
    if (o.done === 1'b1) done_cnt++;
    if (o.busy === 1'b1 && int'(o.addr) > max_addr) max_addr = int'(o.addr);
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h want %0h (sel %0d, t=%0t)",
                 nm, got, want, sel, $time);
    end
  endtask

  function automatic logic rnd_bit();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    chk("busy", o.busy, e_busy);
    chk("ss_act", o.act, e_busy);
    chk("done", o.done, e_done);
    chk("ss_we", o.we, e_we);
    chk("buf_req", o.req, e_req);
    if (e_req) chk("buf_we", o.bwe, e_bwe);
    if (e_busy) begin
      chk("ss_addr", o.addr, e_addr);
      chk("buf_addr", o.baddr, e_addr);
    end
    chk("ss_wdat", o.wdat, e_wdat);
    chk("buf_wdat", o.bwdat, e_bwdat);
    save_req = 1'b0;
    load_req = 1'b0;
    map_rst  = 1'b0;
    ack      = 1'b0;
    brdat    = 8'($urandom);
  endtask

  task automatic clr_cnt();
    wr_cnt = 0; stb_cnt = 0; rst_cnt = 0; done_cnt = 0; max_addr = 0;
  endtask

  task automatic do_reset(logic with_req);
    map_rst = 1'b1;
    save_req = with_req;
    load_req = with_req;
    e_busy = 0; e_done = 0; e_we = 0; e_req = 0; e_bwe = 0;
    e_addr = 0; e_wdat = 0; e_bwdat = 0;
    cyc();
    chk("rst ss_addr", o.addr, 0);
    chk("rst buf_we", o.bwe, 0);
    cyc();
  endtask

  task automatic run_save(int len, int maxd, logic both);
    save_req = 1'b1;
    load_req = both;
    e_busy = 1; e_done = 0; e_req = 0; e_we = 0; e_addr = 0;
    cyc();
    for (int b = 0; b < len; b++) begin
      ack = rnd_bit(); save_req = rnd_bit(); load_req = rnd_bit();
      cyc();
      e_bwdat = map_mem[b];
      e_req = 1; e_bwe = 1;
      ack = rnd_bit(); load_req = rnd_bit();
      cyc();
      repeat ((b == hold_b) ? hold_d : $urandom_range(0, maxd)) begin
        save_req = rnd_bit(); load_req = rnd_bit();
        cyc();
      end
      ack = 1'b1;
      e_req = 0;
      e_addr = 8'(b + 1);
      e_done = (b == len - 1);
      cyc();
    end
    e_busy = 0; e_done = 0;
    save_req = rnd_bit(); load_req = rnd_bit(); ack = rnd_bit();
    cyc();
  endtask

  task automatic run_load(int len, int we_len, int maxd, int abort_b);
    load_req = 1'b1;
    e_busy = 1; e_done = 0; e_req = 1; e_bwe = 0; e_we = 0; e_addr = 0;
    cyc();
    for (int b = 0; b < len; b++) begin
      repeat ($urandom_range(0, maxd)) begin
        save_req = rnd_bit(); load_req = rnd_bit();
        cyc();
      end
      ack = 1'b1;
      brdat = buf_mem[b];
      e_wdat = buf_mem[b];
      e_req = 0; e_we = 1;
      cyc();
      if (b == abort_b) begin
        map_rst = 1'b1; save_req = 1'b1;
        e_busy = 0; e_we = 0; e_wdat = 0; e_bwdat = 0;
        cyc();
        return;
      end
      repeat (we_len - 1) begin
        ack = rnd_bit(); save_req = rnd_bit();
        cyc();
      end
      e_we = 0;
      e_addr = 8'(b + 1);
      e_done = (b == len - 1);
      e_req = (b != len - 1);
      ack = rnd_bit();
      cyc();
    end
    e_busy = 0; e_done = 0; e_req = 0;
    save_req = rnd_bit(); load_req = rnd_bit();
    cyc();
  endtask

  function automatic int diff_cnt(int len);
    int n = 0;
    for (int i = 0; i < len; i++)
      if (map_wr[i] !== buf_mem[i]) n++;
    return n;
  endfunction

  function automatic int save_diff(int len);
    int n = 0;
    for (int i = 0; i < len; i++)
      if (buf_mem[i] !== map_mem[i]) n++;
    return n;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   k;
    logic [7:0] pat [4];
    n_run = 0; n_fail = 0;
    save_req = 0; load_req = 0; map_rst = 0; ack = 0; brdat = 0;
    hold_b = -1; hold_d = 0; we_prev = 0;
    for (int i = 0; i < 256; i++) begin
      map_mem[i] = 8'($urandom); buf_mem[i] = 0; map_wr[i] = 0;
    end
    clr_cnt();

    // SS_LEN=4 instance: reset wins over simultaneous requests.
    sel = 0;
    do_reset(1'b1);

    pat = '{8'h02, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 4; i++) map_mem[i] = pat[i];
    clr_cnt();
    run_save(4, 0, 1'b0);
    chk("save4 buf0", buf_mem[0], 8'h02);
    chk("save4 buf1", buf_mem[1], 8'h11);
    chk("save4 buf2", buf_mem[2], 8'h22);
    chk("save4 buf3", buf_mem[3], 8'h33);
    chk("save4 writes", wr_cnt, 4);
    chk("save4 done", done_cnt, 1);

    clr_cnt();
    run_save(4, 3, 1'b1);
    chk("both strobes", stb_cnt, 0);
    chk("both writes", wr_cnt, 4);

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) map_mem[i] = 8'($urandom);
        clr_cnt();
        run_save(4, 4, 1'b0);
        chk("rnd save data", save_diff(4), 0);
      end else begin
        for (int i = 0; i < 4; i++) begin
          buf_mem[i] = 8'($urandom); map_wr[i] = ~buf_mem[i];
        end
        clr_cnt();
        run_load(4, 2, 4, -1);
        chk("rnd load data", diff_cnt(4), 0);
        chk("rnd load strobes", stb_cnt, 4);
      end
      k = $urandom_range(0, 3);
      repeat (k) begin
        ack = rnd_bit();
        cyc();
      end
    end

    // SS_LEN=128 instance: full load, stalled save, aborted load.
    sel = 1;
    do_reset(1'b0);
    buf_mem[0] = 8'h03;
    for (int i = 1; i < 128; i++) buf_mem[i] = 8'hFF;
    for (int i = 0; i < 256; i++) map_wr[i] = 0;
    clr_cnt();
    run_load(128, 4, 0, -1);
    chk("load128 strobes", stb_cnt, 128);
    chk("load128 mapper rst", rst_cnt, 1);
    chk("load128 byte0", map_wr[0], 8'h03);
    chk("load128 byte127", map_wr[127], 8'hFF);
    chk("load128 data", diff_cnt(128), 0);
    chk("load128 done", done_cnt, 1);

    for (int i = 0; i < 256; i++) map_mem[i] = 8'($urandom);
    hold_b = 2; hold_d = 50;
    clr_cnt();
    run_save(128, 2, 1'b0);
    hold_b = -1;
    chk("stall writes", wr_cnt, 128);
    chk("stall data", save_diff(128), 0);

    for (int i = 0; i < 128; i++) buf_mem[i] = 8'($urandom);
    clr_cnt();
    run_load(128, 4, 2, 5);
    repeat (3) cyc();
    chk("abort done", done_cnt, 0);
    chk("abort strobes", stb_cnt, 6);
    run_save(128, 1, 1'b0);
    chk("post-abort done", done_cnt, 1);

    // SS_LEN=256 instance: full-range save without wrap.
    sel = 2;
    do_reset(1'b0);
    for (int i = 0; i < 256; i++) map_mem[i] = 8'($urandom);
    clr_cnt();
    run_save(256, 1, 1'b0);
    chk("save256 writes", wr_cnt, 256);
    chk("save256 max addr", max_addr, 255);
    chk("save256 done", done_cnt, 1);
    chk("save256 data", save_diff(256), 0);
    repeat (4) cyc();
    chk("save256 idle done", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
